// File: rtl/smart_home_pkg.sv
// Shared constants and the sensor channel index for the smart-home front end.
package smart_home_pkg;

    localparam int unsigned TEMP_W          = 7;
    localparam int unsigned NUM_SENSORS     = 4;
    localparam int unsigned DEB_CYCLES_DEF  = 16;
    localparam int unsigned TEMP_STABLE_DEF = 8;
    localparam logic [TEMP_W-1:0] RST_TEMP_DEF = 7'd25;

    typedef enum logic [1:0] {
        FD = 2'd0,
        RD = 2'd1,
        W  = 2'd2,
        FA = 2'd3
    } sensor_idx_e;

endpackage

// File: rtl/sensor_conditioner_if.sv
// Raw sensor inputs and conditioned outputs between the sensors and the controller.
interface sensor_conditioner_if;
    import smart_home_pkg::*;

    logic              raw_fd;
    logic              raw_rd;
    logic              raw_w;
    logic              raw_fa;
    logic [TEMP_W-1:0] raw_t;
    logic              SFD;
    logic              SRD;
    logic              SW;
    logic              SFA;
    logic [TEMP_W-1:0] ST;
    logic              st_valid;
    logic              st_upd;

    // master: sensor side driving raw values and consuming clean ones
    modport master (
        output raw_fd, raw_rd, raw_w, raw_fa, raw_t,
        input  SFD, SRD, SW, SFA, ST, st_valid, st_upd
    );

    // slave: the conditioner itself
    modport slave (
        input  raw_fd, raw_rd, raw_w, raw_fa, raw_t,
        output SFD, SRD, SW, SFA, ST, st_valid, st_upd
    );

endinterface

// File: rtl/sensor_debounce.sv
// One binary sensor channel: 2-flop synchroniser followed by a saturating-free debounce counter.
module sensor_debounce #(
    parameter int unsigned DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_clean
);

    localparam int unsigned CNT_W = $clog2(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_out_d;
    logic             w_s;

    assign w_s = r_sync[1];

    always_comb begin
        w_cnt_d = r_cnt;
        w_out_d = r_out;
        if (w_s == r_out) begin
            w_cnt_d = '0;
        end else if (r_cnt == CNT_MAX) begin
            w_out_d = w_s;
            w_cnt_d = '0;
        end else begin
            w_cnt_d = r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_cnt  <= '0;
            r_out  <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            r_cnt  <= w_cnt_d;
            r_out  <= w_out_d;
        end
    end

    assign o_clean = r_out;

endmodule

// File: rtl/sensor_conditioner.sv
// Synchronises and debounces the binary sensors and stability-qualifies the temperature bus.
module sensor_conditioner
    import smart_home_pkg::*;
#(
    parameter int unsigned       DEB_CYCLES  = DEB_CYCLES_DEF,
    parameter int unsigned       TEMP_STABLE = TEMP_STABLE_DEF,
    parameter logic [TEMP_W-1:0] RST_TEMP    = RST_TEMP_DEF
) (
    input logic                 clk,
    input logic                 Rst,
    sensor_conditioner_if.slave bus
);

    localparam int unsigned TCNT_W = $clog2(TEMP_STABLE);
    localparam logic [TCNT_W-1:0] TCNT_CAP = TCNT_W'(TEMP_STABLE - 2);
    localparam logic [TCNT_W-1:0] TCNT_SAT = TCNT_W'(TEMP_STABLE - 1);

    logic [NUM_SENSORS-1:0] w_raw;
    logic [NUM_SENSORS-1:0] w_clean;

    assign w_raw[FD] = bus.raw_fd;
    assign w_raw[RD] = bus.raw_rd;
    assign w_raw[W]  = bus.raw_w;
    assign w_raw[FA] = bus.raw_fa;

    for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_deb
        sensor_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst_n  (Rst),
            .i_raw  (w_raw[g]),
            .o_clean(w_clean[g])
        );
    end

    assign bus.SFD = w_clean[FD];
    assign bus.SRD = w_clean[RD];
    assign bus.SW  = w_clean[W];
    assign bus.SFA = w_clean[FA];

    logic [TEMP_W-1:0] r_tmeta;
    logic [TEMP_W-1:0] r_tsync;
    logic [TEMP_W-1:0] r_tp;
    logic [TCNT_W-1:0] r_tcnt;
    logic [TEMP_W-1:0] r_st;
    logic              r_st_valid;
    logic              r_st_upd;
    logic [TCNT_W-1:0] w_tcnt_d;
    logic [TEMP_W-1:0] w_st_d;
    logic              w_st_valid_d;
    logic              w_st_upd_d;

    // Counter parks at TCNT_SAT after a capture so a steady bus never re-captures.
    always_comb begin
        w_tcnt_d     = r_tcnt;
        w_st_d       = r_st;
        w_st_valid_d = r_st_valid;
        w_st_upd_d   = 1'b0;
        if (r_tsync != r_tp) begin
            w_tcnt_d = '0;
        end else if (r_tcnt == TCNT_CAP) begin
            w_st_d       = r_tsync;
            w_st_upd_d   = 1'b1;
            w_st_valid_d = 1'b1;
            w_tcnt_d     = TCNT_SAT;
        end else if (r_tcnt < TCNT_SAT) begin
            w_tcnt_d = r_tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge Rst) begin
        if (!Rst) begin
            r_tmeta    <= '0;
            r_tsync    <= '0;
            r_tp       <= '0;
            r_tcnt     <= '0;
            r_st       <= RST_TEMP;
            r_st_valid <= 1'b0;
            r_st_upd   <= 1'b0;
        end else begin
            r_tmeta    <= bus.raw_t;
            r_tsync    <= r_tmeta;
            r_tp       <= r_tsync;
            r_tcnt     <= w_tcnt_d;
            r_st       <= w_st_d;
            r_st_valid <= w_st_valid_d;
            r_st_upd   <= w_st_upd_d;
        end
    end

    assign bus.ST       = r_st;
    assign bus.st_valid = r_st_valid;
    assign bus.st_upd   = r_st_upd;

endmodule

// File: tb/tb_sensor_conditioner.sv
// Directed bench for sensor_conditioner with DEB_CYCLES=4 and TEMP_STABLE=8.
module tb_sensor_conditioner;

    logic clk;
    logic Rst;
    int   n_checks;
    int   n_errors;
    int   n_upd;
    int   n_hi;
    int   n_flips;
    int   rise_edge;
    logic prev_sw;

    sensor_conditioner_if bus ();

    sensor_conditioner #(
        .DEB_CYCLES (4),
        .TEMP_STABLE(8),
        .RST_TEMP   (7'd25)
    ) u_dut (
        .clk(clk),
        .Rst(Rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle on the following falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        Rst        = 1'b0;
        bus.raw_fd = 1'b0;
        bus.raw_rd = 1'b0;
        bus.raw_w  = 1'b0;
        bus.raw_fa = 1'b0;
        bus.raw_t  = 7'd40;
        repeat (2) @(negedge clk);

        check_eq("rst_sensors", {bus.SFA, bus.SW, bus.SRD, bus.SFD}, 0);
        check_eq("rst_st", bus.ST, 25);
        check_eq("rst_valid", bus.st_valid, 0);
        check_eq("rst_upd", bus.st_upd, 0);

        // First temperature capture lands on edge 10 after release.
        Rst   = 1'b1;
        n_upd = 0;
        for (int e = 1; e <= 20; e++) begin
            step();
            if (bus.st_upd) n_upd++;
            if (e == 9) begin
                check_eq("st_pre_cap", bus.ST, 25);
                check_eq("valid_pre_cap", bus.st_valid, 0);
            end
            if (e == 10) begin
                check_eq("st_cap", bus.ST, 40);
                check_eq("upd_cap", bus.st_upd, 1);
                check_eq("valid_cap", bus.st_valid, 1);
            end
        end
        check_eq("upd_count_init", n_upd, 1);
        check_eq("sensors_idle", {bus.SFA, bus.SW, bus.SRD, bus.SFD}, 0);

        // Clean front-door edge: visible on the 6th edge counting the sampling edge.
        bus.raw_fd = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e == 5) check_eq("sfd_edge5", bus.SFD, 0);
            if (e == 6) check_eq("sfd_edge6", bus.SFD, 1);
        end
        bus.raw_fd = 1'b0;
        repeat (8) step();
        check_eq("sfd_fall", bus.SFD, 0);

        // Three-cycle glitch must be swallowed.
        n_hi       = 0;
        bus.raw_fd = 1'b1;
        repeat (3) begin
            step();
            if (bus.SFD) n_hi++;
        end
        bus.raw_fd = 1'b0;
        repeat (8) begin
            step();
            if (bus.SFD) n_hi++;
        end
        check_eq("sfd_glitch", n_hi, 0);

        // Window toggling every 2 cycles, then held high.
        n_flips   = 0;
        rise_edge = 0;
        prev_sw   = bus.SW;
        for (int k = 0; k < 4; k++) begin
            bus.raw_w = (k % 2 == 0);
            repeat (2) begin
                step();
                if (bus.SW != prev_sw) n_flips++;
                prev_sw = bus.SW;
            end
        end
        check_eq("sw_toggle_flips", n_flips, 0);
        bus.raw_w = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            if (bus.SW != prev_sw) begin
                n_flips++;
                if (rise_edge == 0) rise_edge = e;
            end
            prev_sw = bus.SW;
        end
        check_eq("sw_flips", n_flips, 1);
        check_eq("sw_rise_edge", rise_edge, 6);

        // Alternating temperature never qualifies.
        n_upd = 0;
        for (int p = 0; p < 4; p++) begin
            bus.raw_t = (p % 2 == 0) ? 7'd41 : 7'd40;
            repeat (5) begin
                step();
                if (bus.st_upd) n_upd++;
            end
        end
        check_eq("alt_upd", n_upd, 0);
        check_eq("alt_st", bus.ST, 40);

        bus.raw_t = 7'd41;
        n_upd     = 0;
        repeat (20) begin
            step();
            if (bus.st_upd) n_upd++;
        end
        check_eq("hold41_upd", n_upd, 1);
        check_eq("hold41_st", bus.ST, 41);

        // Fire alarm and rear door together.
        bus.raw_fa = 1'b1;
        bus.raw_rd = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e == 5) check_eq("fa_rd_edge5", {bus.SFA, bus.SRD}, 2'b00);
            if (e == 6) check_eq("fa_rd_edge6", {bus.SFA, bus.SRD}, 2'b11);
        end

        // Reset with SFD's counter at 2: everything returns at once.
        bus.raw_fd = 1'b1;
        repeat (4) step();
        check_eq("sfd_pre_rst", bus.SFD, 0);
        Rst = 1'b0;
        #1;
        check_eq("mid_rst_sfd", bus.SFD, 0);
        check_eq("mid_rst_st", bus.ST, 25);
        check_eq("mid_rst_valid", bus.st_valid, 0);
        check_eq("mid_rst_sfa", bus.SFA, 0);
        @(negedge clk);
        check_eq("rst_hold_sw", bus.SW, 0);
        Rst = 1'b1;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e == 5) check_eq("post_rst_edge5", bus.SFD, 0);
            if (e == 6) check_eq("post_rst_edge6", bus.SFD, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sensor_conditioner.md
Name: sensor_conditioner

Overview:
- Front-end stage that sits directly upstream of the smart-home controller FSM.
- Synchronises the four raw binary sensors (front door, rear door, window, fire alarm) into clk and debounces them.
- Synchronises the raw 7-bit temperature bus and qualifies it by stability.
- Presents clean SFD/SRD/SW/SFA/ST values to the controller, plus a temperature-valid flag and an update strobe.

Parameters:
- DEB_CYCLES, 16, consecutive synced cycles a binary input must differ from its output before the output flips; legal range 2..65535.
- TEMP_STABLE, 8, consecutive synced cycles the temperature bus must hold one value before it is captured; legal range 2..65535.
- RST_TEMP, 7'd25, value driven on ST while in reset and until the first capture.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- Rst  in  1  asynchronous, active-low reset (0 = reset asserted).
- raw_fd  in  1  raw front-door sensor, asynchronous to clk.
- raw_rd  in  1  raw rear-door sensor, asynchronous.
- raw_w  in  1  raw window sensor, asynchronous.
- raw_fa  in  1  raw fire-alarm sensor, asynchronous.
- raw_t  in  7  raw temperature code, unsigned, asynchronous.
- SFD  out  1  debounced front-door sensor to controller.
- SRD  out  1  debounced rear-door sensor.
- SW  out  1  debounced window sensor.
- SFA  out  1  debounced fire-alarm sensor.
- ST  out  7  qualified temperature to controller.
- st_valid  out  1  1 once ST holds at least one captured sample.
- st_upd  out  1  one-cycle pulse on every capture into ST.

Behaviour:
- Reset (Rst=0, asynchronous): clears all synchroniser flops, all debounce counters and SFD/SRD/SW/SFA to 0; ST=RST_TEMP; st_valid=0; st_upd=0; temperature stability counter cleared. Release is synchronous to the next edge.
- Synchronisation: each raw bit passes through a 2-flop synchroniser; s = second-stage output. raw_t uses 2 flops per bit; any skew is absorbed by the stability check.
- Debounce, per bit, with counter cnt of width clog2(DEB_CYCLES):
  - s == out: cnt <= 0.
  - s != out and cnt == DEB_CYCLES-1: out <= s, cnt <= 0.
  - otherwise: cnt <= cnt+1.
- Debounce timing:
  - A clean raw edge appears on the output 2+DEB_CYCLES rising edges after the first edge that samples it.
  - Any glitch shorter than DEB_CYCLES synced cycles produces no output change; the counter restarts from 0 when the input returns.
  - A counter never wraps.
- The four channels are fully independent. Simultaneous changes on several channels flip in the same cycle if their timing is identical.
- Temperature path, with tp = previous synced value (register) and tcnt = counter:
  - tsync != tp: tcnt <= 0.
  - else if tcnt == TEMP_STABLE-2: ST <= tsync, st_upd <= 1, st_valid <= 1, tcnt <= TEMP_STABLE-1 (saturates, no repeat capture).
  - else if tcnt < TEMP_STABLE-1: tcnt <= tcnt+1.
  - tp <= tsync every cycle.
- Temperature capture rules:
  - Net effect: capture after TEMP_STABLE consecutive equal synced samples; st_upd pulses once per distinct stable value.
  - After a capture, a steady bus produces no further st_upd.
  - Any change restarts qualification. A change back to the currently held ST value re-qualifies and pulses st_upd again; this is acceptable.
- st_upd is 0 in every cycle it is not explicitly set.
- Reset mid-count: all progress is lost. Outputs return to reset values immediately, without waiting for clk.

Decomposition:
- Shared package smart_home_pkg holds:
  - TEMP_W=7
  - default DEB_CYCLES/TEMP_STABLE
  - RST_TEMP
  - a sensor index enum (FD, RD, W, FA) used to vector the four channels.
- One sub-module, sensor_debounce: 1-bit, 2-flop sync plus counter, parameter DEB_CYCLES. Instantiated four times.
- The temperature path stays inline in the top.

Test Plan (DEB_CYCLES=4, TEMP_STABLE=8):
- Reset, then hold all raw inputs 0 with raw_t=40 for 20 cycles: SFD..SFA stay 0; st_valid rises; one st_upd pulse; ST=40 at edge 2+8 after release.
- raw_fd 0->1 held: SFD rises exactly 6 edges after the sampling edge. raw_fd pulse of 3 cycles: SFD stays 0.
- raw_w toggled 1,0,1,0 every 2 cycles, then held 1: SW changes only after 4 consecutive synced 1s; no intermediate flips.
- raw_t alternates 40/41 every 5 cycles: no st_upd and ST unchanged. raw_t then held 41: single st_upd, ST=41.
- raw_fa and raw_rd rise on the same edge: SFA and SRD rise on the same cycle, 6 edges later.
- Rst pulsed low while SFD's counter is at 2 and ST=41: immediately SFD=0, ST=25, st_valid=0. After release, a held raw_fd=1 needs the full 6 edges again.
